// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR run sequencer.
// Holds the FSM encoding, tap geometry and reset coefficient table.
package fir_pkg;

  localparam int N_TAPS = 5;
  localparam int COEF_W = 12;

  // {c4,c3,c2,c1,c0}, tap0 in the LSBs
  localparam logic [N_TAPS*COEF_W-1:0] COEF_RST = {
    12'h652, 12'hca0, 12'h41d, 12'hc9d, 12'h25d
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/fir_valid_pipe.sv
// One-bit valid shift chain with synchronous clear.
// Delays a strobe by DEPTH cycles (DEPTH >= 1).
module fir_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
    if (clr) begin
      sr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/fir_sequencer.sv
// Run controller and coefficient bank for the 5-tap FIR datapath.
// Streams N_SAMPLES words memory -> filter -> memory, then pulses done.
module fir_sequencer
  import fir_pkg::*;
#(
  parameter int N_SAMPLES  = 256,
  parameter int ADDR_W     = 8,
  parameter int MEM_RD_LAT = 1,
  parameter int PIPE_LAT   = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       coef_wr_en,
  input  logic [2:0]                 coef_wr_idx,
  input  logic [COEF_W-1:0]          coef_wr_data,
  output logic [N_TAPS*COEF_W-1:0]   coef_bus,
  output logic                       in_rd_en,
  output logic [ADDR_W-1:0]          in_addr,
  output logic                       fir_clr,
  output logic                       fir_en,
  output logic                       out_wr_en,
  output logic [ADDR_W-1:0]          out_addr,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SAMPLES - 1);

  state_t state_q, state_d;
  logic [ADDR_W-1:0] in_cnt_q, in_cnt_d;
  logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
  logic [N_TAPS*COEF_W-1:0] coef_q, coef_d;
  logic cfg_err_q, cfg_err_d;
  logic idx_ok;

  assign busy   = (state_q != S_IDLE);
  assign idx_ok = (coef_wr_idx < 3'(N_TAPS));

  always_comb begin
    coef_d    = coef_q;
    cfg_err_d = 1'b0;
    if (coef_wr_en) begin
      if (busy || !idx_ok) begin
        cfg_err_d = 1'b1;
      end else begin
        for (int i = 0; i < N_TAPS; i++) begin
          if (coef_wr_idx == 3'(i)) begin
            coef_d[i*COEF_W +: COEF_W] = coef_wr_data;
          end
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    fir_clr   = 1'b0;
    in_rd_en  = 1'b0;
    done      = 1'b0;
    if (out_wr_en && out_cnt_q != LAST) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        fir_clr   = 1'b1;
        in_cnt_d  = '0;
        out_cnt_d = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        in_rd_en = 1'b1;
        if (in_cnt_q == LAST) begin
          state_d = S_DRAIN;
        end else begin
          in_cnt_d = in_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_wr_en && out_cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        in_cnt_d  = '0;
        out_cnt_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // abort overrides every transition above
    if (abort) begin
      state_d   = S_IDLE;
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      coef_q    <= COEF_RST;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      coef_q    <= coef_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  fir_valid_pipe #(.DEPTH(MEM_RD_LAT)) u_rd_pipe (
    .clk  (clk),
    .rstn (rstn),
    .clr  (abort),
    .d    (in_rd_en),
    .q    (fir_en)
  );

  fir_valid_pipe #(.DEPTH(PIPE_LAT)) u_wr_pipe (
    .clk  (clk),
    .rstn (rstn),
    .clr  (abort),
    .d    (fir_en),
    .q    (out_wr_en)
  );

  assign in_addr  = in_cnt_q;
  assign out_addr = out_cnt_q;
  assign coef_bus = coef_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer: timing, abort, coef bank, reset.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_fir_sequencer;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        abort;
  logic        coef_wr_en;
  logic [2:0]  coef_wr_idx;
  logic [11:0] coef_wr_data;
  logic [59:0] coef_bus;
  logic        in_rd_en;
  logic [7:0]  in_addr;
  logic        fir_clr;
  logic        fir_en;
  logic        out_wr_en;
  logic [7:0]  out_addr;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  localparam logic [59:0] DEF_COEF = {
    12'h652, 12'hca0, 12'h41d, 12'hc9d, 12'h25d
  };

  fir_sequencer dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .abort        (abort),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_idx  (coef_wr_idx),
    .coef_wr_data (coef_wr_data),
    .coef_bus     (coef_bus),
    .in_rd_en     (in_rd_en),
    .in_addr      (in_addr),
    .fir_clr      (fir_clr),
    .fir_en       (fir_en),
    .out_wr_en    (out_wr_en),
    .out_addr     (out_addr),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    obs = {busy, done, fir_clr, in_rd_en, fir_en, out_wr_en, cfg_err};
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 0000000", obs);
    end
    checks++;
    if (coef_bus !== DEF_COEF) begin
      errors++;
      $display("FAIL reset_coef got %h want %h", coef_bus, DEF_COEF);
    end
    checks++;
    if (in_addr !== 8'd0 || out_addr !== 8'd0) begin
      errors++;
      $display("FAIL reset_addr got %0d/%0d want 0/0", in_addr, out_addr);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_full_run();
    logic [5:0] obs, exp;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 262; k++) begin
      exp = {k == 1, k >= 2 && k <= 257, k >= 3 && k <= 258,
             k >= 4 && k <= 259, k == 260, k <= 260};
      obs = {fir_clr, in_rd_en, fir_en, out_wr_en, done, busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL run_strobes k=%0d got %b want %b", k, obs, exp);
      end
      if (exp[4]) begin
        checks++;
        if (in_addr !== 8'(k - 2)) begin
          errors++;
          $display("FAIL run_in_addr k=%0d got %0d want %0d",
                   k, in_addr, k - 2);
        end
      end
      if (exp[2]) begin
        checks++;
        if (out_addr !== 8'(k - 4)) begin
          errors++;
          $display("FAIL run_out_addr k=%0d got %0d want %0d",
                   k, out_addr, k - 4);
        end
      end
      if (k < 262) step();
    end
  endtask

  task automatic test_abort();
    logic [4:0] obs;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 102; k++) step();
    checks++;
    if (in_addr !== 8'd100 || in_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre in_addr got %0d want 100", in_addr);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    obs = {busy, in_rd_en, fir_en, out_wr_en, done};
    checks++;
    if (obs !== 5'b0) begin
      errors++;
      $display("FAIL abort_strobes got %b want 00000", obs);
    end
    checks++;
    if (in_addr !== 8'd0 || out_addr !== 8'd0) begin
      errors++;
      $display("FAIL abort_addr got %0d/%0d want 0/0", in_addr, out_addr);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || out_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet cyc=%0d got done=%b busy=%b wr=%b want 0",
                 k, done, busy, out_wr_en);
      end
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (in_rd_en !== 1'b1 || in_addr !== 8'd0) begin
      errors++;
      $display("FAIL restart_in got rd=%b addr=%0d want 1/0", in_rd_en, in_addr);
    end
    step();
    step();
    checks++;
    if (out_wr_en !== 1'b1 || out_addr !== 8'd0) begin
      errors++;
      $display("FAIL restart_out got wr=%b addr=%0d want 1/0",
               out_wr_en, out_addr);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_coef();
    logic [59:0] exp;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    coef_wr_en   = 1'b1;
    coef_wr_idx  = 3'd2;
    coef_wr_data = 12'h7ff;
    step();
    coef_wr_en = 1'b0;
    checks++;
    if (cfg_err !== 1'b1 || coef_bus !== DEF_COEF) begin
      errors++;
      $display("FAIL coef_busy got err=%b bus=%h want 1/%h",
               cfg_err, coef_bus, DEF_COEF);
    end
    step();
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL coef_err_pulse got %b want 0", cfg_err);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp = DEF_COEF;
    exp[24 +: 12] = 12'h7ff;
    coef_wr_en   = 1'b1;
    coef_wr_idx  = 3'd2;
    coef_wr_data = 12'h7ff;
    step();
    coef_wr_en = 1'b0;
    checks++;
    if (cfg_err !== 1'b0 || coef_bus !== exp) begin
      errors++;
      $display("FAIL coef_idle got err=%b bus=%h want 0/%h",
               cfg_err, coef_bus, exp);
    end
    coef_wr_en   = 1'b1;
    coef_wr_idx  = 3'd5;
    coef_wr_data = 12'h000;
    step();
    coef_wr_en = 1'b0;
    checks++;
    if (cfg_err !== 1'b1 || coef_bus !== exp) begin
      errors++;
      $display("FAIL coef_bad_idx got err=%b bus=%h want 1/%h",
               cfg_err, coef_bus, exp);
    end
    exp[0 +: 12] = 12'h123;
    start        = 1'b1;
    coef_wr_en   = 1'b1;
    coef_wr_idx  = 3'd0;
    coef_wr_data = 12'h123;
    step();
    start      = 1'b0;
    coef_wr_en = 1'b0;
    checks++;
    if (fir_clr !== 1'b1 || cfg_err !== 1'b0 || coef_bus !== exp) begin
      errors++;
      $display("FAIL coef_with_start got clr=%b err=%b bus=%h want 1/0/%h",
               fir_clr, cfg_err, coef_bus, exp);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_start_busy();
    int nwr   = 0;
    int ndone = 0;
    int donek = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 262; k++) begin
      if (out_wr_en) nwr++;
      if (done) begin
        ndone++;
        donek = k;
      end
      start = (k == 50);
      step();
    end
    start = 1'b0;
    checks++;
    if (nwr !== 256) begin
      errors++;
      $display("FAIL busy_start_writes got %0d want 256", nwr);
    end
    checks++;
    if (ndone !== 1 || donek !== 260) begin
      errors++;
      $display("FAIL busy_start_done got n=%0d at k=%0d want 1 at 260",
               ndone, donek);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_drain();
    logic [6:0] obs;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 258; k++) step();
    checks++;
    if (out_wr_en !== 1'b1 || busy !== 1'b1 || in_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL drain_pre got wr=%b busy=%b rd=%b want 1/1/0",
               out_wr_en, busy, in_rd_en);
    end
    #2;
    rstn = 1'b0;
    #1;
    obs = {busy, done, fir_clr, in_rd_en, fir_en, out_wr_en, cfg_err};
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL drain_rst_strobes got %b want 0000000", obs);
    end
    checks++;
    if (in_addr !== 8'd0 || out_addr !== 8'd0) begin
      errors++;
      $display("FAIL drain_rst_addr got %0d/%0d want 0/0", in_addr, out_addr);
    end
    checks++;
    if (coef_bus !== DEF_COEF) begin
      errors++;
      $display("FAIL drain_rst_coef got %h want %h", coef_bus, DEF_COEF);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step();
  endtask

  initial begin
    rstn         = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    coef_wr_en   = 1'b0;
    coef_wr_idx  = 3'd0;
    coef_wr_data = 12'h000;
    test_reset();
    test_full_run();
    test_abort();
    test_coef();
    test_start_busy();
    test_reset_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
